// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_arb_pkg: shared definitions for the FIFO write arbiter.
// Holds the FSM state encoding and the default parameter values used by
// the interface, the round-robin picker and the arbiter top.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_MAX_BURST  = 4;

endpackage : fifo_arb_pkg

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: bundle of the requester side and FIFO write-port side
// signals of the arbiter.
//   req_i        : per-requester write request, bit k = requester k
//   wdata_i      : packed payloads, slice k = requester k
//   gnt_o        : one-hot grant, zero when idle
//   fifo_wr_en_o : write strobe into the FIFO
//   fifo_wdata_o : {owner ID, owner payload}
//   fifo_full_i  : FIFO full flag
//   busy_o       : high while a burst is in progress
// Modports: slave = arbiter side, master = environment side.
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ID_W       = $clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]            req_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i;
  logic [NUM_REQ-1:0]            gnt_o;
  logic                          fifo_wr_en_o;
  logic [ID_W+DATA_WIDTH-1:0]    fifo_wdata_o;
  logic                          fifo_full_i;
  logic                          busy_o;

  modport slave (
    input  req_i,
    input  wdata_i,
    input  fifo_full_i,
    output gnt_o,
    output fifo_wr_en_o,
    output fifo_wdata_o,
    output busy_o
  );

  modport master (
    output req_i,
    output wdata_i,
    output fifo_full_i,
    input  gnt_o,
    input  fifo_wr_en_o,
    input  fifo_wdata_o,
    input  busy_o
  );

endinterface : fifo_wr_arbiter_if

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   i_req        : request vector
//   i_last_owner : index of the previous owner
//   o_valid      : at least one request is set
//   o_owner      : first requester found searching upward from
//                  (i_last_owner+1) mod NUM_REQ, with wrap
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_last_owner,
  output logic               o_valid,
  output logic [ID_W-1:0]    o_owner
);

  // w_cand[gi] is the requester visited at search position gi.
  // One spare bit holds the unwrapped sum so non power-of-two NUM_REQ wraps.
  logic [ID_W:0]   w_sum  [NUM_REQ];
  logic [ID_W-1:0] w_cand [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      assign w_sum[gi]  = (ID_W+1)'(i_last_owner) + (ID_W+1)'(gi + 1);
      assign w_cand[gi] = (w_sum[gi] >= (ID_W+1)'(NUM_REQ))
                        ? ID_W'(w_sum[gi] - (ID_W+1)'(NUM_REQ))
                        : w_sum[gi][ID_W-1:0];
    end
  endgenerate

  // Walk from the farthest position back to the nearest so the nearest
  // active requester is the one left standing.
  always_comb begin
    o_valid = 1'b0;
    o_owner = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (i_req[w_cand[i]]) begin
        o_valid = 1'b1;
        o_owner = w_cand[i];
      end
    end
  end

endmodule : rr_pick

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: grants one of NUM_REQ requesters access to a FIFO write
// port for a burst of up to MAX_BURST beats, round-robin between bursts.
//   clk : clock, all state on its rising edge
//   rst : synchronous active-high reset
//   bus : fifo_wr_arbiter_if.slave (requests, payloads, grant, FIFO write
//         port, full flag, busy)
// Arbitration takes one IDLE cycle; writes only occur in BURST and are
// driven combinationally from the owner's request and the full flag.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_BURST  = DEF_MAX_BURST
) (
  input  logic               clk,
  input  logic               rst,
  fifo_wr_arbiter_if.slave   bus
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  arb_state_t         r_state;
  logic [ID_W-1:0]    r_owner;
  logic [ID_W-1:0]    r_last_owner;
  logic [CNT_W-1:0]   r_beat;
  logic [NUM_REQ-1:0] r_gnt;

  logic                  w_pick_valid;
  logic [ID_W-1:0]       w_pick_owner;
  logic                  w_owner_req;
  logic [DATA_WIDTH-1:0] w_owner_data;
  logic                  w_in_burst;
  logic                  w_beat;
  logic                  w_last_beat;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .i_req        (bus.req_i),
    .i_last_owner (r_last_owner),
    .o_valid      (w_pick_valid),
    .o_owner      (w_pick_owner)
  );

  assign w_owner_req  = bus.req_i[r_owner];
  assign w_owner_data = bus.wdata_i[r_owner*DATA_WIDTH +: DATA_WIDTH];

  // Reset gates the write path so an aborted burst cannot leak a beat.
  assign w_in_burst  = (r_state == BURST) & ~rst;
  assign w_beat      = w_in_burst & w_owner_req & ~bus.fifo_full_i;
  assign w_last_beat = w_beat & (r_beat == CNT_W'(MAX_BURST - 1));

  assign bus.gnt_o        = r_gnt;
  assign bus.busy_o       = (r_state == BURST);
  assign bus.fifo_wr_en_o = w_beat;
  assign bus.fifo_wdata_o = w_in_burst ? {r_owner, w_owner_data} : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_owner      <= '0;
      r_last_owner <= ID_W'(NUM_REQ - 1);
      r_beat       <= '0;
      r_gnt        <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_valid) begin
            r_owner <= w_pick_owner;
            r_gnt   <= NUM_REQ'(1) << w_pick_owner;
            r_beat  <= '0;
            r_state <= BURST;
          end
        end
        BURST: begin
          // A full FIFO only stalls; release comes from the owner dropping
          // its request or from the final beat of the burst.
          if (!w_owner_req || w_last_beat) begin
            r_state      <= IDLE;
            r_gnt        <= '0;
            r_last_owner <= r_owner;
          end else if (w_beat) begin
            r_beat <= r_beat + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= '0;
        end
      endcase
    end
  end

endmodule : fifo_wr_arbiter

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed checks of reset, round-robin order, full
// stalls, early release and reset abort, followed by a random phase that
// checks grant one-hotness, no write while full, and bounded waiting.
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int STARVE_BOUND = (NR - 1) * (MB + 1) + 1;

  logic clk;
  logic rst;

  int n_tests;
  int n_fail;

  logic [DW-1:0] data_k [NR];

  fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

  fifo_wr_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_wd(input int k);
    logic [1:0] id;
    id = 2'(k);
    return {22'd0, id, data_k[k]};
  endfunction

  // Inputs are set just after a rising edge; outputs are sampled on the
  // following falling edge, then the task advances past the next rise.
  task automatic expect_cycle(input string tag, input logic [31:0] e_gnt,
                              input logic [31:0] e_wr, input logic [31:0] e_wd,
                              input logic [31:0] e_busy);
    @(negedge clk);
    check({tag, ".gnt"},  {28'd0, bus.gnt_o},        e_gnt);
    check({tag, ".wr"},   {31'd0, bus.fifo_wr_en_o}, e_wr);
    check({tag, ".wd"},   {22'd0, bus.fifo_wdata_o}, e_wd);
    check({tag, ".busy"}, {31'd0, bus.busy_o},       e_busy);
    $display("[TB] %s req=%b full=%b gnt=%b wr=%b wd=%h busy=%b", tag,
             bus.req_i, bus.fifo_full_i, bus.gnt_o, bus.fifo_wr_en_o,
             bus.fifo_wdata_o, bus.busy_o);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int order [5];
    int wait_cnt [NR];
    int viol_oh;
    int viol_full;
    int viol_starve;
    int wr_seen;

    n_tests = 0;
    n_fail  = 0;
    data_k[0] = 8'hA0;
    data_k[1] = 8'hB1;
    data_k[2] = 8'hC2;
    data_k[3] = 8'hD3;
    order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;

    rst             = 1'b1;
    bus.req_i       = '0;
    bus.fifo_full_i = 1'b0;
    bus.wdata_i     = {data_k[3], data_k[2], data_k[1], data_k[0]};
    @(posedge clk);
    @(posedge clk);
    #1;

    // Single requester, full burst then release.
    expect_cycle("a_rst", 0, 0, 0, 0);
    rst       = 1'b0;
    bus.req_i = 4'b0001;
    expect_cycle("a_idle", 0, 0, 0, 0);
    for (int b = 0; b < MB; b++) expect_cycle("a_beat", 4'b0001, 1, exp_wd(0), 1);
    bus.req_i = 4'b0000;
    expect_cycle("a_rel", 0, 0, 0, 0);

    // All requesting: strict rotation starting from requester 0.
    rst = 1'b1;
    expect_cycle("b_rst", 0, 0, 0, 0);
    rst       = 1'b0;
    bus.req_i = 4'b1111;
    for (int s = 0; s < 5; s++) begin
      expect_cycle("b_idle", 0, 0, 0, 0);
      for (int b = 0; b < MB; b++)
        expect_cycle("b_beat", 32'd1 << order[s], 1, exp_wd(order[s]), 1);
    end
    bus.req_i = 4'b0000;
    expect_cycle("b_rel", 0, 0, 0, 0);

    // Owner 2 stalled by a full FIFO for three cycles mid-burst.
    bus.req_i = 4'b0100;
    expect_cycle("c_idle", 0, 0, 0, 0);
    expect_cycle("c_beat1", 4'b0100, 1, exp_wd(2), 1);
    expect_cycle("c_beat2", 4'b0100, 1, exp_wd(2), 1);
    bus.fifo_full_i = 1'b1;
    for (int f = 0; f < 3; f++) expect_cycle("c_full", 4'b0100, 0, exp_wd(2), 1);
    bus.fifo_full_i = 1'b0;
    expect_cycle("c_beat3", 4'b0100, 1, exp_wd(2), 1);
    expect_cycle("c_beat4", 4'b0100, 1, exp_wd(2), 1);
    bus.req_i = 4'b0000;
    expect_cycle("c_rel", 0, 0, 0, 0);

    // Owner 1 drops its request after two beats; next search starts at 2.
    bus.req_i = 4'b0010;
    expect_cycle("d_idle", 0, 0, 0, 0);
    expect_cycle("d_beat1", 4'b0010, 1, exp_wd(1), 1);
    expect_cycle("d_beat2", 4'b0010, 1, exp_wd(1), 1);
    bus.req_i = 4'b1101;
    expect_cycle("d_drop", 4'b0010, 0, exp_wd(1), 1);
    expect_cycle("d_idle2", 0, 0, 0, 0);
    expect_cycle("d_next", 4'b0100, 1, exp_wd(2), 1);
    bus.req_i = 4'b0000;
    expect_cycle("d_drop2", 4'b0100, 0, exp_wd(2), 1);
    expect_cycle("d_rel", 0, 0, 0, 0);

    // Reset during beat 2 of owner 3 aborts; requester 0 wins afterwards.
    bus.req_i = 4'b1000;
    expect_cycle("e_idle", 0, 0, 0, 0);
    expect_cycle("e_beat1", 4'b1000, 1, exp_wd(3), 1);
    rst = 1'b1;
    expect_cycle("e_rst", 4'b1000, 0, 0, 1);
    rst       = 1'b0;
    bus.req_i = 4'b1111;
    expect_cycle("e_after", 0, 0, 0, 0);
    expect_cycle("e_grant0", 4'b0001, 1, exp_wd(0), 1);
    bus.req_i = 4'b0000;
    expect_cycle("e_drop", 4'b0001, 0, exp_wd(0), 1);
    expect_cycle("e_rel", 0, 0, 0, 0);

    // Random phase with sticky requests and sporadic full.
    viol_oh     = 0;
    viol_full   = 0;
    viol_starve = 0;
    wr_seen     = 0;
    for (int k = 0; k < NR; k++) wait_cnt[k] = 0;
    for (int c = 0; c < 10000; c++) begin
      for (int k = 0; k < NR; k++)
        if ($urandom_range(0, 31) == 0) bus.req_i[k] = ~bus.req_i[k];
      bus.fifo_full_i = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      if ((bus.gnt_o & (bus.gnt_o - 4'd1)) != 4'd0) viol_oh++;
      if (bus.fifo_wr_en_o && bus.fifo_full_i) viol_full++;
      if (bus.fifo_wr_en_o) wr_seen++;
      for (int k = 0; k < NR; k++) begin
        if (!bus.req_i[k] || bus.gnt_o[k]) wait_cnt[k] = 0;
        else if (!bus.fifo_full_i) wait_cnt[k]++;
        if (wait_cnt[k] > STARVE_BOUND) begin
          viol_starve++;
          wait_cnt[k] = 0;
        end
      end
      @(posedge clk);
      #1;
    end
    check("rand_onehot",   viol_oh,          0);
    check("rand_wr_full",  viol_full,        0);
    check("rand_starve",   viol_starve,      0);
    check("rand_wr_seen",  {31'd0, wr_seen > 0}, 1);
    $display("[TB] random phase: %0d writes", wr_seen);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_fifo_wr_arbiter
